// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform bitmap write-back path.
//   IMG_DIM  : image width and height in pixels (square image)
//   PIX_W    : pixel width of the res RAM
//   WORD_W   : bitmap word width (pixels per packed word)
//   PIX_AW   : pixel address width, {y[6:0],x[6:0]}
//   WORD_AW  : bitmap word address width
//   dt_state_e : packer control FSM states
//   dt_is_border() : true for pixels on the outer ring of the image
package dt_pkg;
  localparam int IMG_DIM = 128;
  localparam int PIX_W   = 8;
  localparam int WORD_W  = 16;
  localparam int PIX_AW  = 14;
  localparam int WORD_AW = 10;
  localparam int XY_W    = 7;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} dt_state_e;

  function automatic logic dt_is_border(input logic [PIX_AW-1:0] a);
    logic [XY_W-1:0] x, y;
    x = a[XY_W-1:0];
    y = a[PIX_AW-1:XY_W];
    return (x == '0) || (y == '0) ||
           (x == XY_W'(IMG_DIM-1)) || (y == XY_W'(IMG_DIM-1));
  endfunction
endpackage

// File: rtl/dt_bit_packer.sv
// 16-bit shift accumulator. Bits enter at the LSB, so the first bit of a
// group ends up in the word MSB. On the bit flagged 'last' the completed
// word (including that bit) is published with a one-cycle word_vld.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   bit_in          pixel bit
//   bit_vld         bit_in is valid this cycle
//   last            this bit completes a word
//   word            last completed word, held between completions
//   word_vld        one-cycle strobe for a new word
module dt_bit_packer
  import dt_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_vld,
  input  logic         last,
  output logic [W-1:0] word,
  output logic         word_vld
);
  // Only W-1 bits of history are needed; the W-th bit is the incoming one.
  logic [W-2:0] shift;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift    <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= bit_vld & last;
      if (bit_vld) begin
        shift <= {shift[W-3:0], bit_in};
        if (last) word <= {shift, bit_in};
      end
    end
  end
endmodule

// File: rtl/dt_bitmap_packer.sv
// Reads the 128x128 8-bit res map in raster order, thresholds each pixel
// (pixel >= thr -> 1) and packs 16 pixels MSB-first into 1024 bitmap words.
// Build option: DT_ZERO_BORDER_EN forces bits of pixels with x or y equal
// to 0 or 127 to 0; otherwise border pixels are thresholded normally.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   start        run request, honoured only in IDLE / DONE
//   thr_sel,thr  threshold select / runtime threshold, latched with start
//   busy, done   run status
//   res_rd, res_addr, res_di   res RAM read port (1-cycle read latency)
//   pk_wr, pk_addr, pk_do      bitmap RAM write port
module dt_bitmap_packer
  import dt_pkg::*;
#(
  parameter logic [PIX_W-1:0] DEF_THR = 8'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               thr_sel,
  input  logic [PIX_W-1:0]   thr,
  output logic               busy,
  output logic               done,
  output logic               res_rd,
  output logic [PIX_AW-1:0]  res_addr,
  input  logic [PIX_W-1:0]   res_di,
  output logic               pk_wr,
  output logic [WORD_AW-1:0] pk_addr,
  output logic [WORD_W-1:0]  pk_do
);
  dt_state_e             state, state_nxt;
  logic                  accept, last_addr, drain_cnt;
  logic [PIX_W-1:0]      thr_l;
  logic                  pix_vld;   // res_di holds pixel pix_addr this cycle
  logic [PIX_AW-1:0]     pix_addr;
  logic                  pix_bit, pix_last;

  // Status and read strobe are plain decodes of the state register.
  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == DONE);
  assign res_rd    = (state == READ);
  assign last_addr = (res_addr == '1);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = READ;
        accept    = 1'b1;
      end
      READ:  if (last_addr) state_nxt = DRAIN;
      // Two drain cycles let the final pixel reach the packer and the
      // last word be written before done is raised.
      DRAIN: if (drain_cnt) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_addr  <= '0;
      thr_l     <= '0;
      drain_cnt <= 1'b0;
      pix_vld   <= 1'b0;
      pix_addr  <= '0;
    end else begin
      if (accept) begin
        res_addr <= '0;
        thr_l    <= thr_sel ? thr : DEF_THR;
      end else if (state == READ && !last_addr) begin
        // Address parks at the last pixel; it never wraps back to 0.
        res_addr <= res_addr + 1'b1;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      pix_vld   <= res_rd;
      pix_addr  <= res_addr;
    end
  end

`ifdef DT_ZERO_BORDER_EN
  assign pix_bit = (res_di >= thr_l) && !dt_is_border(pix_addr);
`else
  assign pix_bit = (res_di >= thr_l);
`endif
  assign pix_last = &pix_addr[3:0];

  dt_bit_packer #(.W(WORD_W)) u_pack (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (pix_bit),
    .bit_vld  (pix_vld),
    .last     (pix_last),
    .word     (pk_do),
    .word_vld (pk_wr)
  );

  // Word address captured on the same edge the packer publishes its word.
  always_ff @(posedge clk) begin
    if (!reset)                   pk_addr <= '0;
    else if (pix_vld && pix_last) pk_addr <= pix_addr[PIX_AW-1:4];
  end
endmodule
